// File: rtl/fifo_wr_sched.sv
// Write-side scheduler for the multi-port fifo: round-robin grant of up to
// WRITE producers per cycle, packed onto lanes 0..k-1, plus flush sequencing.
module fifo_wr_sched #(
  parameter int   REQ   = 8,
  parameter int   WRITE = 4,
  parameter int   DATA  = 64,
  parameter logic ACT   = 1'b0,
  parameter int   CNTW  = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [REQ-1:0]               req_valid,
  input  logic [REQ-1:0][DATA-1:0]     req_data,
  output logic [REQ-1:0]               req_ready,
  output logic [WRITE-1:0]             fifo_we,
  output logic [WRITE-1:0][DATA-1:0]   fifo_wd,
  output logic                         fifo_flush_,
  input  logic                         fifo_busy,
  input  logic                         flush_req,
  output logic                         flush_ack,
  output logic [$clog2(WRITE):0]       grant_cnt,
  output logic [CNTW-1:0]              accept_total
);

  localparam int PW = (REQ > 1) ? $clog2(REQ) : 1;
  localparam int CW = $clog2(WRITE) + 1;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   ptr_nxt;
  logic [PW-1:0]   last;
  logic [PW-1:0]   idx;
  logic [PW:0]     sum;
  logic [CW-1:0]   cnt;
  logic            gen;
  logic [CNTW:0]   acc_sum;
  logic [CNTW-1:0] acc_nxt;

  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:     if (flush_req) state_nxt = FLUSH;
      FLUSH:   state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  assign gen = (state == RUN) && !flush_req && !fifo_busy && !reset;

  // Scan from ptr; the k-th winner lands on lane k
  always_comb begin
    req_ready = '0;
    fifo_we   = {WRITE{~ACT}};
    fifo_wd   = '0;
    cnt       = '0;
    last      = '0;
    sum       = '0;
    idx       = '0;
    if (gen) begin
      for (int i = 0; i < REQ; i++) begin
        sum = {1'b0, ptr} + (PW+1)'(i);
        if (sum >= (PW+1)'(REQ))
          idx = PW'(sum - (PW+1)'(REQ));
        else
          idx = PW'(sum);
        if (req_valid[idx] && cnt < CW'(WRITE)) begin
          req_ready[idx] = 1'b1;
          for (int l = 0; l < WRITE; l++) begin
            if (CW'(l) == cnt) begin
              fifo_we[l] = ACT;
              fifo_wd[l] = req_data[idx];
            end
          end
          cnt  = cnt + CW'(1);
          last = idx;
        end
      end
    end
  end

  assign grant_cnt   = cnt;
  assign fifo_flush_ = !(reset || state == FLUSH);
  assign flush_ack   = (state == FLUSH) && !reset;

  assign ptr_nxt = (last == PW'(REQ-1)) ? '0 : last + PW'(1);

  assign acc_sum = {1'b0, accept_total} + (CNTW+1)'(cnt);
  assign acc_nxt = acc_sum[CNTW] ? {CNTW{1'b1}} : acc_sum[CNTW-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      ptr          <= '0;
      accept_total <= '0;
    end else begin
      state        <= state_nxt;
      accept_total <= acc_nxt;
      if (state == FLUSH)
        ptr <= '0;
      else if (cnt != '0)
        ptr <= ptr_nxt;
    end
  end

endmodule
